// File: rtl/muldiv_hilo_unit.sv
// muldiv_hilo_unit
// Iterative multiply/divide unit with architectural HI/LO registers.
// Multiplies use radix-2 shift-add, divides use restoring shift-subtract,
// both on operand magnitudes; signs are applied in a final FINISH cycle.
//
// state  | meaning
// IDLE   | waiting for start; MTHI/MTLO write HI/LO directly
// CALC   | one shift-add / shift-subtract step per enabled edge
// FINISH | sign correction, HI/LO write, done pulse
//
// Ports
//   clk     - clock, rising edge
//   rst     - asynchronous reset, active low
//   en      - advance enable; 0 freezes all state
//   start   - operation request, sampled in IDLE only
//   op      - 001 MULT, 010 MULTU, 011 DIV, 100 DIVU, 101 MTHI, 110 MTLO
//   a, b    - operands (a is the value written by MTHI/MTLO)
//   rd_sel  - 10 reads HI, 01 reads LO, otherwise rd_data is 0
//   rd_data - selected register
//   hi, lo  - HI/LO contents
//   busy    - iterative operation in progress
//   done    - one-cycle pulse when HI/LO take a MULT/DIV result
//   stall   - read of HI/LO requested while busy
module muldiv_hilo_unit #(
   parameter int WIDTH = 32,
   parameter int CNT_W = $clog2(WIDTH + 1)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic             start,
   input  logic [2:0]       op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic [1:0]       rd_sel,
   output logic [WIDTH-1:0] rd_data,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo,
   output logic             busy,
   output logic             done,
   output logic             stall
);

   localparam logic [2:0] OP_MULT  = 3'b001;
   localparam logic [2:0] OP_MULTU = 3'b010;
   localparam logic [2:0] OP_DIV   = 3'b011;
   localparam logic [2:0] OP_DIVU  = 3'b100;
   localparam logic [2:0] OP_MTHI  = 3'b101;
   localparam logic [2:0] OP_MTLO  = 3'b110;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_CALC   = 2'd1,
      ST_FINISH = 2'd2
   } state_t;

   state_t state_q, state_nxt;

   logic [CNT_W-1:0] cnt_q;
   // acc holds the high product half (mul) or partial remainder (div);
   // mq holds the multiplier/low product (mul) or dividend/quotient (div).
   logic [WIDTH:0]   acc_q;
   logic [WIDTH-1:0] mq_q;
   logic [WIDTH-1:0] mcand_q;
   logic [WIDTH-1:0] a_raw_q;
   logic [WIDTH-1:0] hi_q;
   logic [WIDTH-1:0] lo_q;
   logic             is_div_q;
   logic             div0_q;
   logic             neg_q;
   logic             neg_r_q;
   logic             done_q;

   logic             is_iter;
   logic             is_signed;
   logic             is_div_op;
   logic             a_neg;
   logic             b_neg;
   logic [WIDTH-1:0] abs_a;
   logic [WIDTH-1:0] abs_b;

   always_comb begin
      is_iter   = (op == OP_MULT) || (op == OP_MULTU) || (op == OP_DIV) || (op == OP_DIVU);
      is_signed = (op == OP_MULT) || (op == OP_DIV);
      is_div_op = (op == OP_DIV) || (op == OP_DIVU);
      a_neg     = is_signed & a[WIDTH-1];
      b_neg     = is_signed & b[WIDTH-1];
      abs_a     = a_neg ? -a : a;
      abs_b     = b_neg ? -b : b;
   end

   logic [WIDTH:0]   mul_sum;
   logic [WIDTH:0]   div_shift;
   logic [WIDTH+1:0] div_diff;
   logic [WIDTH:0]   acc_step;
   logic [WIDTH-1:0] mq_step;

   always_comb begin
      mul_sum   = mq_q[0] ? (acc_q + {1'b0, mcand_q}) : acc_q;
      div_shift = {acc_q[WIDTH-1:0], mq_q[WIDTH-1]};
      // One extra bit so the sign of the trial subtraction is the borrow.
      div_diff  = {1'b0, div_shift} - {2'b00, mcand_q};
      acc_step  = '0;
      mq_step   = '0;
      if (is_div_q) begin
         if (!div_diff[WIDTH+1]) begin
            acc_step = div_diff[WIDTH:0];
            mq_step  = {mq_q[WIDTH-2:0], 1'b1};
         end else begin
            acc_step = div_shift;
            mq_step  = {mq_q[WIDTH-2:0], 1'b0};
         end
      end else begin
         acc_step = {1'b0, mul_sum[WIDTH:1]};
         mq_step  = {mul_sum[0], mq_q[WIDTH-1:1]};
      end
   end

   logic [2*WIDTH-1:0] prod_mag;
   logic [2*WIDTH-1:0] prod;
   logic [WIDTH-1:0]   rem_mag;
   logic [WIDTH-1:0]   quo;
   logic [WIDTH-1:0]   rem;
   logic [WIDTH-1:0]   res_hi;
   logic [WIDTH-1:0]   res_lo;

   always_comb begin
      prod_mag = {acc_q[WIDTH-1:0], mq_q};
      prod     = neg_q ? -prod_mag : prod_mag;
      rem_mag  = acc_q[WIDTH-1:0];
      quo      = neg_q ? -mq_q : mq_q;
      rem      = neg_r_q ? -rem_mag : rem_mag;
      res_hi   = prod[2*WIDTH-1:WIDTH];
      res_lo   = prod[WIDTH-1:0];
      if (is_div_q) begin
         // Divide by zero returns all-ones quotient and the untouched dividend.
         if (div0_q) begin
            res_hi = a_raw_q;
            res_lo = '1;
         end else begin
            res_hi = rem;
            res_lo = quo;
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state_q <= ST_IDLE;
      else      state_q <= state_nxt;
   end

   always_comb begin
      state_nxt = state_q;
      case (state_q)
         ST_IDLE:   if (en && start && is_iter) state_nxt = ST_CALC;
         ST_CALC:   if (en && (cnt_q == CNT_W'(1))) state_nxt = ST_FINISH;
         ST_FINISH: if (en) state_nxt = ST_IDLE;
         default:   state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cnt_q    <= '0;
         acc_q    <= '0;
         mq_q     <= '0;
         mcand_q  <= '0;
         a_raw_q  <= '0;
         hi_q     <= '0;
         lo_q     <= '0;
         is_div_q <= 1'b0;
         div0_q   <= 1'b0;
         neg_q    <= 1'b0;
         neg_r_q  <= 1'b0;
         done_q   <= 1'b0;
      end else begin
         done_q <= 1'b0;
         if (en) begin
            case (state_q)
               ST_IDLE: begin
                  if (start) begin
                     if (is_iter) begin
                        cnt_q    <= CNT_W'(WIDTH);
                        acc_q    <= '0;
                        a_raw_q  <= a;
                        is_div_q <= is_div_op;
                        div0_q   <= (b == '0);
                        neg_q    <= a_neg ^ b_neg;
                        neg_r_q  <= a_neg;
                        if (is_div_op) begin
                           mq_q    <= abs_a;
                           mcand_q <= abs_b;
                        end else begin
                           mq_q    <= abs_b;
                           mcand_q <= abs_a;
                        end
                     end else if (op == OP_MTHI) begin
                        hi_q <= a;
                     end else if (op == OP_MTLO) begin
                        lo_q <= a;
                     end
                  end
               end
               ST_CALC: begin
                  acc_q <= acc_step;
                  mq_q  <= mq_step;
                  cnt_q <= cnt_q - CNT_W'(1);
               end
               ST_FINISH: begin
                  hi_q   <= res_hi;
                  lo_q   <= res_lo;
                  done_q <= 1'b1;
               end
               default: ;
            endcase
         end
      end
   end

   always_comb begin
      case (rd_sel)
         2'b10:   rd_data = hi_q;
         2'b01:   rd_data = lo_q;
         default: rd_data = '0;
      endcase
   end

   assign hi    = hi_q;
   assign lo    = lo_q;
   assign busy  = (state_q != ST_IDLE);
   assign done  = done_q;
   assign stall = busy && ((rd_sel == 2'b10) || (rd_sel == 2'b01));

endmodule

// File: tb/tb_muldiv_hilo_unit.sv
module tb_muldiv_hilo_unit;
   localparam int W = 32;

   logic         clk = 1'b0;
   logic         rst;
   logic         en;
   logic         start;
   logic [2:0]   op;
   logic [W-1:0] a;
   logic [W-1:0] b;
   logic [1:0]   rd_sel;
   logic [W-1:0] rd_data;
   logic [W-1:0] hi;
   logic [W-1:0] lo;
   logic         busy;
   logic         done;
   logic         stall;

   muldiv_hilo_unit #(.WIDTH(W)) dut (
      .clk(clk), .rst(rst), .en(en), .start(start), .op(op), .a(a), .b(b),
      .rd_sel(rd_sel), .rd_data(rd_data), .hi(hi), .lo(lo),
      .busy(busy), .done(done), .stall(stall)
   );

   always #5 clk = ~clk;

   int n_total = 0;
   int n_pass  = 0;
   logic [W-1:0] m_hi = '0;
   logic [W-1:0] m_lo = '0;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   // Reference results from plain 64-bit arithmetic.
   function automatic void model(input logic [2:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                                 output logic [W-1:0] eh, output logic [W-1:0] el);
      longint          sx = $signed(x);
      longint          sy = $signed(y);
      longint unsigned ux = x;
      longint unsigned uy = y;
      logic [63:0]     p;
      eh = '0;
      el = '0;
      case (o)
         3'b001: begin p = sx * sy; eh = p[63:32]; el = p[31:0]; end
         3'b010: begin p = ux * uy; eh = p[63:32]; el = p[31:0]; end
         3'b011, 3'b100: begin
            if (y == '0) begin
               el = '1;
               eh = x;
            end else if (o == 3'b011) begin
               p = sx / sy; el = p[31:0];
               p = sx % sy; eh = p[31:0];
            end else begin
               p = ux / uy; el = p[31:0];
               p = ux % uy; eh = p[31:0];
            end
         end
         default: ;
      endcase
   endfunction

   // Issue an iterative op; freeze en for gl edges after edge gs (gl=0: none).
   task automatic run_op(input logic [2:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                         input int gs, input int gl);
      logic [W-1:0] eh, el;
      int edges;
      bit got;
      model(o, x, y, eh, el);
      op = o; a = x; b = y; start = 1'b1; en = 1'b1;
      @(posedge clk); #1;
      start = 1'b0; a = $urandom; b = $urandom;
      chk("busy_after_start", busy, 1);
      edges = 0;
      got = 0;
      while (!got && edges < 200) begin
         en = !(edges >= gs && edges < gs + gl);
         if (edges == 5) begin op = 3'b101; start = 1'b1; end
         if (edges == 6) begin op = o; start = 1'b0; end
         @(posedge clk); #1;
         edges++;
         if (done) got = 1;
         else if (edges == 3) begin
            rd_sel = 2'b01; #1;
            chk("stall_lo_read", stall, 1);
            chk("rd_old_lo", rd_data, m_lo);
            chk("hi_held", hi, m_hi);
            rd_sel = 2'b00;
         end else if (edges == 10) begin
            chk("hi_after_ignored_start", hi, m_hi);
         end
      end
      en = 1'b1; start = 1'b0; op = o;
      chk("latency", edges, 33 + gl);
      chk("res_hi", hi, eh);
      chk("res_lo", lo, el);
      chk("busy_at_done", busy, 0);
      m_hi = eh;
      m_lo = el;
      @(posedge clk); #1;
      chk("done_one_cycle", done, 0);
   endtask

   task automatic move_to(input logic [2:0] o, input logic [W-1:0] x);
      op = o; a = x; start = 1'b1; en = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      if (o == 3'b101) begin m_hi = x; rd_sel = 2'b10; end
      else begin m_lo = x; rd_sel = 2'b01; end
      #1;
      chk("mt_rd_data", rd_data, x);
      chk("mt_busy", busy, 0);
      chk("mt_done", done, 0);
      rd_sel = 2'b11; #1;
      chk("rd_none", rd_data, 0);
      rd_sel = 2'b00;
   endtask

   initial begin
      logic [2:0] ro;
      logic [W-1:0] rx, ry;
      int gs, gl;
      bit saw_done;

      rst = 1'b1; en = 1'b0; start = 1'b0; op = '0; a = '0; b = '0; rd_sel = 2'b00;
      #2 rst = 1'b0;
      #1;
      chk("rst_hi", hi, 0);
      chk("rst_lo", lo, 0);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      repeat (2) @(posedge clk);
      #1 rst = 1'b1;

      run_op(3'b001, 32'hFFFFFFFD, 32'd7, 0, 0);
      run_op(3'b010, 32'hFFFFFFFF, 32'hFFFFFFFF, 0, 0);
      run_op(3'b011, 32'hFFFFFFF9, 32'd2, 0, 0);
      run_op(3'b100, 32'h12345678, 32'd0, 0, 0);
      run_op(3'b011, 32'h80000000, 32'hFFFFFFFF, 0, 0);
      run_op(3'b011, 32'h80000001, 32'd0, 0, 0);
      run_op(3'b001, 32'h7FFFFFFF, 32'h80000000, 10, 5);

      move_to(3'b101, 32'hA5A5A5A5);
      move_to(3'b110, 32'h5A5A0F0F);

      op = 3'b000; a = 32'h11111111; start = 1'b1;
      @(posedge clk); #1;
      op = 3'b111;
      @(posedge clk); #1;
      start = 1'b0;
      chk("none_busy", busy, 0);
      chk("none_hi", hi, m_hi);
      chk("none_lo", lo, m_lo);

      for (int i = 0; i < 16; i++) begin
         ro = 3'($urandom_range(1, 4));
         rx = $urandom;
         ry = $urandom;
         if (i % 5 == 0) ry = '0;
         if (i % 4 == 1) ry = 32'($urandom_range(1, 15));
         gs = 0; gl = 0;
         if (i % 3 == 0) begin gs = $urandom_range(2, 20); gl = $urandom_range(1, 8); end
         run_op(ro, rx, ry, gs, gl);
      end

      op = 3'b011; a = 32'd1000; b = 32'd3; start = 1'b1; en = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (9) @(posedge clk);
      #1 rst = 1'b0;
      #1;
      chk("abort_hi", hi, 0);
      chk("abort_lo", lo, 0);
      chk("abort_busy", busy, 0);
      m_hi = '0;
      m_lo = '0;
      saw_done = 0;
      repeat (3) begin
         @(posedge clk); #1;
         if (done) saw_done = 1;
      end
      rst = 1'b1;
      chk("abort_no_done", saw_done, 0);
      run_op(3'b100, 32'd100, 32'd7, 0, 0);
      chk("divu_100_7_lo", lo, 14);
      chk("divu_100_7_hi", hi, 2);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end
endmodule

// File: doc/muldiv_hilo_unit.md
MULDIV_HILO_UNIT -- requirements
Module: muldiv_hilo_unit

Interface
REQ-001 Parameter WIDTH, default 32, operand/HI/LO width; SHALL be even and >= 4.
REQ-002 Parameter CNT_W, default $clog2(WIDTH+1), iteration counter width.
REQ-003 clk  in  1  single clock; all state SHALL update on rising edge.
REQ-004 rst  in  1  reset, asynchronous, active-low.
REQ-005 en  in  1  advance enable; 0 SHALL freeze state, counter and HI/LO.
REQ-006 start  in  1  request; sampled only in IDLE with en=1.
REQ-007 op  in  3  operation: 000 NONE, 001 MULT, 010 MULTU, 011 DIV, 100 DIVU, 101 MTHI, 110 MTLO, 111 NONE.
REQ-008 a, b  in  WIDTH  operands (multiplicand/dividend a, multiplier/divisor b; MTHI/MTLO write a).
REQ-009 rd_sel  in  2  read select: 10 HI, 01 LO, 00/11 none.
REQ-010 rd_data  out  WIDTH  selected register; 0 when rd_sel is 00 or 11.
REQ-011 hi, lo  out  WIDTH  HI/LO register contents.
REQ-012 busy  out  1  high while an iterative operation is in progress.
REQ-013 done  out  1  one-cycle pulse when HI/LO receive a MULT/DIV result.
REQ-014 stall  out  1  busy AND rd_sel in {10,01}.

Function
REQ-015 State machine SHALL have states IDLE, CALC, FINISH.
REQ-016 IDLE, en=1, start=1, op in MULT/MULTU/DIV/DIVU: SHALL latch |a|,|b| (signed ops) or a,b (unsigned), record result signs, load counter=WIDTH, go to CALC; busy=1 from next cycle.
REQ-017 IDLE, en=1, start=1, op=MTHI/MTLO: SHALL write a to HI/LO at that edge; stay IDLE; busy and done stay 0.
REQ-018 IDLE, start=1 with op NONE: no state change.
REQ-019 CALC: each en=1 edge SHALL perform one radix-2 shift-add (mul) or restoring shift-subtract (div) step and decrement counter; counter reaching 0 SHALL move to FINISH.
REQ-020 FINISH, en=1: SHALL apply sign correction, write HI/LO, pulse done for exactly one cycle, deassert busy, return to IDLE.
REQ-021 Latency with en held 1: done and new HI/LO visible in the cycle after edge WIDTH+1 counted from the start-sampling edge (WIDTH=32: 33 edges); each en=0 cycle adds one cycle.
REQ-022 start during CALC/FINISH SHALL be ignored, not queued.
REQ-023 MULT/MULTU: {HI,LO} = full 2*WIDTH-bit product; MULT two's-complement.
REQ-024 DIV/DIVU: LO = quotient, HI = remainder; DIV quotient truncates toward zero, remainder takes dividend sign.
REQ-025 Divide by zero (b=0): SHALL complete with normal latency, LO = all ones, HI = a; no hang.
REQ-026 DIV MIN/-1: LO = MIN (0x80000000 at WIDTH=32), HI = 0.
REQ-027 rd_data, hi, lo SHALL reflect pre-operation HI/LO values while busy=1.
REQ-028 Operand inputs SHALL not be re-sampled after the start edge.

Reset
REQ-029 rst=0 SHALL immediately force IDLE, HI=0, LO=0, counter=0, busy=0, done=0, independent of clk.
REQ-030 rst asserted mid-CALC SHALL abort the operation with no HI/LO write and no done pulse.
REQ-031 First start SHALL be accepted on the first rising edge after rst deasserts.

Verification (WIDTH=32)
REQ-032 MULT a=0xFFFFFFFD(-3), b=7, en=1 -> done 33 edges after start, HI=0xFFFFFFFF, LO=0xFFFFFFEB.
REQ-033 MULTU a=b=0xFFFFFFFF -> HI=0xFFFFFFFE, LO=0x00000001; DIV a=0xFFFFFFF9(-7), b=2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF.
REQ-034 DIVU a=0x12345678, b=0 -> done at normal latency, LO=0xFFFFFFFF, HI=0x12345678.
REQ-035 MTHI a=0xA5A5A5A5 then rd_sel=10 next cycle -> rd_data=0xA5A5A5A5, busy=0, done=0.
REQ-036 MULT started, rd_sel=01 during CALC -> stall=1, rd_data=old LO; en=0 for 5 cycles mid-CALC -> done delayed exactly 5 cycles.
REQ-037 rst=0 at edge 10 of DIV, then new DIVU 100/7 -> no done for aborted op, HI=0 LO=0 after reset, then LO=14, HI=2.
